// File: rtl/hack_pkg.sv
// Types shared by the Hack result stage: word type, width and skid-buffer occupancy states.
package hack_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream/downstream handshake bundle of the ALU result stage.
// The slave modport is the stage's view; master is the side that drives in_* and out_ready.
interface alu_result_stage_if
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_zr;
    logic             out_ng;
    logic             out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_zr,
        input  out_ng
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_zr,
        output out_ng
    );

endinterface

// File: rtl/word_skid_buf.sv
// Generic 2-entry skid buffer: main entry drives the output, skid entry absorbs one word
// while the consumer stalls, so in_ready can come straight from a flop.
module word_skid_buf
    import hack_pkg::*;
#(
    parameter int W = WORD_W + 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    occ_t         state;
    occ_t         state_nx;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_ready_q;
    logic         accept;
    logic         load_main_in;
    logic         load_skid_in;
    logic         load_main_skid;

    assign accept = in_valid & in_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            OCC_EMPTY: begin
                if (accept) state_nx = OCC_ONE;
            end
            OCC_ONE: begin
                if (accept && !out_ready)      state_nx = OCC_TWO;
                else if (!accept && out_ready) state_nx = OCC_EMPTY;
            end
            OCC_TWO: begin
                if (out_ready) state_nx = OCC_ONE;
            end
            default: state_nx = OCC_EMPTY;
        endcase
    end

    // TWO never sees an accept because in_ready is already low there.
    always_comb begin
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        case (state)
            OCC_EMPTY: load_main_in = accept;
            OCC_ONE: begin
                load_main_in = accept & out_ready;
                load_skid_in = accept & ~out_ready;
            end
            OCC_TWO:   load_main_skid = out_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_nx != OCC_TWO);
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_data;
            end else if (load_main_skid) begin
                skid_q <= '0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state != OCC_EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage after the Hack bitwise datapath: buffers words and attaches zr/ng flags.
// Optional ALU_STAGE_PERF_EN adds saturating perf_xfers / perf_stalls counters.
module alu_result_stage
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input logic               clk,
    input logic               reset,
    alu_result_stage_if.slave bus
`ifdef ALU_STAGE_PERF_EN
    ,
    output logic [15:0]       perf_xfers,
    output logic [15:0]       perf_stalls
`endif
);

    localparam int PW = WIDTH + 2;

    logic          in_zr;
    logic          in_ng;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;

    // Flags travel with the word so the output never recomputes them.
    assign in_zr      = ~|bus.in_data;
    assign in_ng      = bus.in_data[WIDTH-1];
    assign in_payload = {in_zr, in_ng, bus.in_data};

    word_skid_buf #(
        .W(PW)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .in_valid (bus.in_valid),
        .in_data  (in_payload),
        .in_ready (bus.in_ready),
        .out_valid(bus.out_valid),
        .out_data (out_payload),
        .out_ready(bus.out_ready)
    );

    assign bus.out_data = out_payload[WIDTH-1:0];
    assign bus.out_ng   = out_payload[WIDTH];
    assign bus.out_zr   = out_payload[WIDTH+1];

`ifdef ALU_STAGE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_xfers  <= '0;
            perf_stalls <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready && perf_xfers != 16'hFFFF) begin
                perf_xfers <= perf_xfers + 16'd1;
            end
            if (bus.out_valid && !bus.out_ready && perf_stalls != 16'hFFFF) begin
                perf_stalls <= perf_stalls + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: queue-based reference model checked every cycle,
// directed literal scenarios, and randomized valid/ready traffic.
module tb_alu_result_stage;
    import hack_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    alu_result_stage_if #(.WIDTH(WORD_W)) bus ();

`ifdef ALU_STAGE_PERF_EN
    logic [15:0] perf_xfers;
    logic [15:0] perf_stalls;
`endif

    alu_result_stage #(
        .WIDTH(WORD_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef ALU_STAGE_PERF_EN
        ,
        .perf_xfers (perf_xfers),
        .perf_stalls(perf_stalls)
`endif
    );

    typedef struct packed {
        logic  zr;
        logic  ng;
        word_t data;
    } entry_t;

    entry_t model_q[$];
    entry_t last_out = '0;
    bit     live = 1'b0;
    bit     prev_reset = 1'b0;
    int     exp_xfers = 0;
    int     exp_stalls = 0;
    int     n_tests = 0;
    int     n_fail = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus from a negedge; returns at the next negedge.
    task automatic applyStimulus(input logic v, input word_t d, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        @(negedge clk);
    endtask

    task automatic doReset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("reset_out_data", {16'b0, bus.out_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    endtask

    // Reference model: occupancy is just the queue length, outputs are the queue head.
    always @(posedge clk) begin
        bit     in_rdy;
        entry_t e;
        if (reset) begin
            model_q.delete();
            last_out   = '0;
            prev_reset = 1'b1;
            live       = 1'b1;
            exp_xfers  = 0;
            exp_stalls = 0;
        end else if (live) begin
            in_rdy = !prev_reset && (model_q.size() < 2);
            if (model_q.size() > 0) begin
                if (bus.out_ready) begin
                    void'(model_q.pop_front());
                    exp_xfers++;
                end else begin
                    exp_stalls++;
                end
            end
            if (bus.in_valid && in_rdy) begin
                e.data = bus.in_data;
                e.zr   = (bus.in_data == 0);
                e.ng   = bus.in_data[WORD_W-1];
                model_q.push_back(e);
            end
            prev_reset = 1'b0;
        end
        #1;
        if (live) begin
            if (model_q.size() > 0) last_out = model_q[0];
            checkOutput("m_out_valid", {31'b0, bus.out_valid}, {31'b0, model_q.size() > 0});
            checkOutput("m_in_ready", {31'b0, bus.in_ready},
                        {31'b0, (!prev_reset && model_q.size() < 2)});
            checkOutput("m_out_data", {16'b0, bus.out_data}, {16'b0, last_out.data});
            checkOutput("m_out_zr", {31'b0, bus.out_zr}, {31'b0, last_out.zr});
            checkOutput("m_out_ng", {31'b0, bus.out_ng}, {31'b0, last_out.ng});
`ifdef ALU_STAGE_PERF_EN
            checkOutput("m_perf_xfers", {16'b0, perf_xfers}, (exp_xfers > 65535) ? 32'hFFFF : exp_xfers);
            checkOutput("m_perf_stalls", {16'b0, perf_stalls}, (exp_stalls > 65535) ? 32'hFFFF : exp_stalls);
`endif
        end
    end

    initial begin
        int in_pct;
        int out_pct;
        word_t d;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // Zero word: zr set, ng clear, one-cycle latency.
        doReset();
        applyStimulus(1'b1, 16'h0000, 1'b1);
        checkOutput("t1_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("t1_data", {16'b0, bus.out_data}, 32'h0000);
        checkOutput("t1_zr", {31'b0, bus.out_zr}, 32'd1);
        checkOutput("t1_ng", {31'b0, bus.out_ng}, 32'd0);

        // Back-to-back stream with consumer always ready.
        applyStimulus(1'b1, 16'h8001, 1'b1);
        checkOutput("t2_data0", {16'b0, bus.out_data}, 32'h8001);
        checkOutput("t2_flags0", {30'b0, bus.out_zr, bus.out_ng}, 32'b01);
        checkOutput("t2_rdy0", {31'b0, bus.in_ready}, 32'd1);
        applyStimulus(1'b1, 16'h00FF, 1'b1);
        checkOutput("t2_data1", {16'b0, bus.out_data}, 32'h00FF);
        checkOutput("t2_flags1", {30'b0, bus.out_zr, bus.out_ng}, 32'b00);
        checkOutput("t2_rdy1", {31'b0, bus.in_ready}, 32'd1);
        applyStimulus(1'b1, 16'h1234, 1'b1);
        checkOutput("t2_data2", {16'b0, bus.out_data}, 32'h1234);
        checkOutput("t2_flags2", {30'b0, bus.out_zr, bus.out_ng}, 32'b00);
        checkOutput("t2_rdy2", {31'b0, bus.in_ready}, 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("t2_drained", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("t2_hold_data", {16'b0, bus.out_data}, 32'h1234);

        // Fill the skid while stalled, then drain in order.
        applyStimulus(1'b1, 16'h0001, 1'b0);
        checkOutput("t3_a", {16'b0, bus.out_data}, 32'h0001);
        applyStimulus(1'b1, 16'h0002, 1'b0);
        checkOutput("t3_full_rdy", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("t3_hold_a", {16'b0, bus.out_data}, 32'h0001);
        applyStimulus(1'b1, 16'h0003, 1'b0);
        checkOutput("t3_blocked_rdy", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("t3_still_a", {16'b0, bus.out_data}, 32'h0001);
        applyStimulus(1'b1, 16'h0003, 1'b1);
        checkOutput("t3_b", {16'b0, bus.out_data}, 32'h0002);
        checkOutput("t3_rdy_back", {31'b0, bus.in_ready}, 32'd1);
        applyStimulus(1'b1, 16'h0003, 1'b1);
        checkOutput("t3_c", {16'b0, bus.out_data}, 32'h0003);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("t3_empty", {31'b0, bus.out_valid}, 32'd0);

        // Reset while two words are held discards both.
        applyStimulus(1'b1, 16'h000A, 1'b0);
        applyStimulus(1'b1, 16'h800B, 1'b0);
        checkOutput("t4_full", {31'b0, bus.in_ready}, 32'd0);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("t4_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("t4_data", {16'b0, bus.out_data}, 32'd0);
        checkOutput("t4_flags", {30'b0, bus.out_zr, bus.out_ng}, 32'd0);
        reset = 1'b0;
        repeat (3) begin
            applyStimulus(1'b0, 16'h0000, 1'b1);
            checkOutput("t4_nothing", {31'b0, bus.out_valid}, 32'd0);
        end

        // Randomized traffic with changing valid/ready densities.
        for (int blk = 0; blk < 10; blk++) begin
            in_pct  = 20 + 20 * (blk % 4);
            out_pct = 90 - 20 * (blk % 5);
            for (int i = 0; i < 1000; i++) begin
                case ($urandom_range(0, 3))
                    0:       d = 16'h0000;
                    1:       d = word_t'($urandom) | 16'h8000;
                    default: d = word_t'($urandom);
                endcase
                applyStimulus($urandom_range(0, 99) < in_pct, d, $urandom_range(0, 99) < out_pct);
            end
        end
        repeat (3) applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("t5_drained", {31'b0, bus.out_valid}, 32'd0);

`ifdef ALU_STAGE_PERF_EN
        // Five output transfers and three stall cycles.
        doReset();
        applyStimulus(1'b1, 16'h0011, 1'b0);
        repeat (3) applyStimulus(1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 16'h0022, 1'b1);
        applyStimulus(1'b1, 16'h0033, 1'b1);
        applyStimulus(1'b1, 16'h0044, 1'b1);
        applyStimulus(1'b1, 16'h0055, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkOutput("t6_xfers", {16'b0, perf_xfers}, 32'd5);
        checkOutput("t6_stalls", {16'b0, perf_stalls}, 32'd3);
        for (int i = 0; i < 65540; i++) applyStimulus(1'b1, word_t'(i), 1'b1);
        repeat (2) applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("t6_sat", {16'b0, perf_xfers}, 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
